instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word-aligned memory requests under a credit
// scheme, tracks in-flight PCs, and buffers returned {pc, instr} pairs for decode.
module instr_fetch #(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] DEPTH = QDEPTH[CW:0];

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  // In-flight request PCs, in issue order
  logic [31:0]   fl_pc [QDEPTH];
  logic [PW-1:0] fl_wr, fl_rd;
  logic [CW-1:0] in_flight;

  // Output queue toward decode
  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [PW-1:0] q_wr, q_rd;
  logic [CW-1:0] queue_count;

  logic [CW-1:0] drop_count, drop_d;
  logic          req_valid;
  logic          rsp_hit;
  logic          rsp_take;
  logic          deq;
  logic          has_credit;

  // Credit uses only registered counts, so a dequeue frees a slot next cycle.
  assign has_credit = ({1'b0, in_flight} + {1'b0, queue_count}) < DEPTH;
  assign rsp_hit    = imem_rsp_valid & (in_flight != '0);

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_count;
    req_valid = 1'b0;
    rsp_take  = 1'b0;
    unique case (state_q)
      RUN: begin
        req_valid = rst & pc_valid & has_credit & ~flush;
        rsp_take  = rsp_hit & ~flush;
        if (flush) begin
          drop_d = in_flight - CW'(rsp_hit);
          if (in_flight - CW'(rsp_hit) != '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid && drop_count != '0) begin
          drop_d = drop_count - 1'b1;
          if (drop_count == CW'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = {pc_in[31:2], 2'b00};
  assign pc_ready       = req_valid & imem_req_ready;

  assign if_valid = (queue_count != '0);
  assign if_pc    = q_pc[q_rd];
  assign if_instr = q_instr[q_rd];
  assign deq      = if_valid & if_ready;

  // NOTE: sequential state uses non-blocking assignments only; the output
  // queue storage is reset because its head is directly visible on if_pc and
  // if_instr, while the in-flight PC storage is not reset since it is only
  // read when in_flight says the entry is live.
  always_ff @(posedge clk) begin
    if (pc_ready) fl_pc[fl_wr] <= pc_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      drop_count  <= '0;
      fl_wr       <= '0;
      fl_rd       <= '0;
      in_flight   <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      queue_count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      drop_count <= drop_d;

      if (flush) begin
        fl_wr       <= '0;
        fl_rd       <= '0;
        in_flight   <= '0;
        q_wr        <= '0;
        q_rd        <= '0;
        queue_count <= '0;
      end else begin
        if (pc_ready) fl_wr <= fl_wr + 1'b1;
        if (rsp_take) begin
          fl_rd         <= fl_rd + 1'b1;
          q_pc[q_wr]    <= fl_pc[fl_rd];
          q_instr[q_wr] <= imem_rsp_data;
          q_wr          <= q_wr + 1'b1;
        end
        if (deq) q_rd <= q_rd + 1'b1;
        in_flight   <= in_flight + CW'(pc_ready) - CW'(rsp_take);
        queue_count <= queue_count + CW'(rsp_take) - CW'(deq);
      end
    end
  end

endmodule
